// File: rtl/dbg_arb_pkg.sv
// Shared definitions for the debug-port arbiter: command encoding,
// FSM state type and the response word returned on a watchdog expiry.
package dbg_arb_pkg;

    localparam logic [7:0]  DBG_CMD_NOP      = 8'h00;
    localparam logic [31:0] DBG_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dbg_rr_picker.sv
// Round-robin winner selection: returns the first requester at or after
// the pointer, wrapping around to the lowest index when none is found.
module dbg_rr_picker
    import dbg_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int IW        = 1
)(
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [IW-1:0]        i_ptr,
    output logic                 o_valid,
    output logic [IW-1:0]        o_winner
);

    logic          w_hiValid;
    logic [IW-1:0] w_hiIdx;
    logic          w_loValid;
    logic [IW-1:0] w_loIdx;

    // Scan downwards so the last hit is the lowest index, both overall and at/after the pointer
    always_comb begin
        w_hiValid = 1'b0;
        w_hiIdx   = '0;
        w_loValid = 1'b0;
        w_loIdx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_loValid = 1'b1;
                w_loIdx   = IW'(i);
                if (IW'(i) >= i_ptr) begin
                    w_hiValid = 1'b1;
                    w_hiIdx   = IW'(i);
                end
            end
        end
    end

    assign o_valid  = w_hiValid | w_loValid;
    assign o_winner = w_hiValid ? w_hiIdx : w_loIdx;

endmodule

// File: rtl/dbg_arbiter.sv
// Round-robin arbiter sharing one DUT debug port between N_MASTERS debug
// masters. A whole transaction (command -> done) is granted at a time; the
// command is latched toward the DUT and the response/done pulse is routed
// back to the granted master only.
// Optional build macro DBG_ARB_TIMEOUT_EN adds a BUSY watchdog
// (TIMEOUT_CYCLES) and the sticky timeout_o flag.
module dbg_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int BITSIZE   = 32,
    parameter int N_MASTERS = 2
`ifdef DBG_ARB_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 1024
`endif
)(
    input  logic                                                   clk,
    input  logic                                                   rstn_i,
    input  logic [N_MASTERS*8-1:0]                                 m_cmd_i,
    input  logic [N_MASTERS*BITSIZE-1:0]                           m_addr_i,
    input  logic [N_MASTERS*BITSIZE-1:0]                           m_data_i,
    output logic [N_MASTERS*BITSIZE-1:0]                           m_data_o,
    output logic [N_MASTERS-1:0]                                   m_ready_o,
    output logic [N_MASTERS-1:0]                                   m_done_o,
    output logic [7:0]                                             dut_cmd_o,
    output logic [BITSIZE-1:0]                                     dut_addr_o,
    output logic [BITSIZE-1:0]                                     dut_data_o,
    input  logic [BITSIZE-1:0]                                     dut_data_i,
    input  logic                                                   dut_ready_i,
    input  logic                                                   dut_done_i,
    output logic [((N_MASTERS > 1) ? $clog2(N_MASTERS) : 1)-1:0]   grant_o,
    output logic                                                   busy_o
`ifdef DBG_ARB_TIMEOUT_EN
    ,output logic                                                  timeout_o
`endif
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_t               r_state;
    logic [IW-1:0]            r_ptr;

    logic [N_MASTERS-1:0]         w_req;
    logic                         w_valid;
    logic [IW-1:0]                w_winner;
    logic [7:0]                   w_selCmd;
    logic [BITSIZE-1:0]           w_selAddr;
    logic [BITSIZE-1:0]           w_selData;
    logic [N_MASTERS-1:0]         w_grantOh;
    logic [BITSIZE-1:0]           w_respData;
    logic [N_MASTERS*BITSIZE-1:0] w_respBus;
    logic                         w_finish;
    logic [IW-1:0]                w_ptrNext;

`ifdef DBG_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_toCnt;
    logic          w_toHit;

    assign w_toHit    = (r_toCnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_finish   = dut_done_i | w_toHit;
    assign w_respData = dut_done_i ? dut_data_i : BITSIZE'(DBG_TIMEOUT_DATA);
`else
    assign w_finish   = dut_done_i;
    assign w_respData = dut_data_i;
`endif

    // Decode request flags and mux out the candidate winner's command fields
    always_comb begin
        w_req     = '0;
        w_selCmd  = DBG_CMD_NOP;
        w_selAddr = '0;
        w_selData = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_req[i] = (m_cmd_i[i*8 +: 8] != DBG_CMD_NOP);
            if (IW'(i) == w_winner) begin
                w_selCmd  = m_cmd_i[i*8 +: 8];
                w_selAddr = m_addr_i[i*BITSIZE +: BITSIZE];
                w_selData = m_data_i[i*BITSIZE +: BITSIZE];
            end
        end
    end

    dbg_rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IW        (IW)
    ) u_picker (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_grantOh = N_MASTERS'(1) << grant_o;
    assign w_ptrNext = (grant_o == IW'(N_MASTERS - 1)) ? '0 : grant_o + 1'b1;

    // Ready is a live view of the DUT, visible only to the master that owns the port
    assign m_ready_o = (r_state == BUSY && dut_ready_i) ? w_grantOh : '0;

    // Place the response word in the granted master's slice, zero elsewhere
    always_comb begin
        w_respBus = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_grantOh[i]) begin
                w_respBus[i*BITSIZE +: BITSIZE] = w_respData;
            end
        end
    end

    // Transaction FSM with all master- and DUT-facing outputs registered
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            grant_o    <= '0;
            dut_cmd_o  <= DBG_CMD_NOP;
            dut_addr_o <= '0;
            dut_data_o <= '0;
            m_data_o   <= '0;
            m_done_o   <= '0;
            busy_o     <= 1'b0;
`ifdef DBG_ARB_TIMEOUT_EN
            r_toCnt    <= '0;
            timeout_o  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    dut_cmd_o <= DBG_CMD_NOP;
                    m_done_o  <= '0;
                    m_data_o  <= '0;
                    if (w_valid && dut_ready_i) begin
                        r_state    <= BUSY;
                        grant_o    <= w_winner;
                        dut_cmd_o  <= w_selCmd;
                        dut_addr_o <= w_selAddr;
                        dut_data_o <= w_selData;
                        busy_o     <= 1'b1;
`ifdef DBG_ARB_TIMEOUT_EN
                        r_toCnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (w_finish) begin
                        r_state   <= RELEASE;
                        dut_cmd_o <= DBG_CMD_NOP;
                        m_done_o  <= w_grantOh;
                        m_data_o  <= w_respBus;
                    end
`ifdef DBG_ARB_TIMEOUT_EN
                    if (w_toHit && !dut_done_i) begin
                        timeout_o <= 1'b1;
                    end
                    r_toCnt <= r_toCnt + 1'b1;
`endif
                end
                RELEASE: begin
                    r_state   <= IDLE;
                    r_ptr     <= w_ptrNext;
                    dut_cmd_o <= DBG_CMD_NOP;
                    m_done_o  <= '0;
                    m_data_o  <= '0;
                    busy_o    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_arbiter.sv
// Self-checking bench for dbg_arbiter (two masters, 32-bit). Expected
// transactions are queued when a master request is driven and popped when
// the DUT side shows the grant. Define DBG_ARB_TIMEOUT_EN to also exercise
// the watchdog with TIMEOUT_CYCLES=16.
module tb_dbg_arbiter;

    localparam int BITSIZE = 32;
    localparam int N       = 2;

    logic              clk = 1'b0;
    logic              rstn_i;
    logic [N*8-1:0]    m_cmd_i;
    logic [N*32-1:0]   m_addr_i;
    logic [N*32-1:0]   m_data_i;
    logic [N*32-1:0]   m_data_o;
    logic [N-1:0]      m_ready_o;
    logic [N-1:0]      m_done_o;
    logic [7:0]        dut_cmd_o;
    logic [31:0]       dut_addr_o;
    logic [31:0]       dut_data_o;
    logic [31:0]       dut_data_i;
    logic              dut_ready_i;
    logic              dut_done_i;
    logic [0:0]        grant_o;
    logic              busy_o;
`ifdef DBG_ARB_TIMEOUT_EN
    logic              timeout_o;
`endif

    typedef struct {
        int          m;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } txn_t;

    txn_t sbq[$];
    txn_t exp;
    int   errors   = 0;
    int   checks   = 0;
    int   modelPtr = 0;

    dbg_arbiter #(
        .BITSIZE        (BITSIZE),
        .N_MASTERS      (N)
`ifdef DBG_ARB_TIMEOUT_EN
        ,.TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .m_cmd_i     (m_cmd_i),
        .m_addr_i    (m_addr_i),
        .m_data_i    (m_data_i),
        .m_data_o    (m_data_o),
        .m_ready_o   (m_ready_o),
        .m_done_o    (m_done_o),
        .dut_cmd_o   (dut_cmd_o),
        .dut_addr_o  (dut_addr_o),
        .dut_data_o  (dut_data_o),
        .dut_data_i  (dut_data_i),
        .dut_ready_i (dut_ready_i),
        .dut_done_i  (dut_done_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
`ifdef DBG_ARB_TIMEOUT_EN
        ,.timeout_o  (timeout_o)
`endif
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Absolute safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one master request and queue the transaction the DUT should carry
    task automatic applyStimulus(input int m, input logic [7:0] cmd,
                                 input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        m_cmd_i[m*8 +: 8]   = cmd;
        m_addr_i[m*32 +: 32] = addr;
        m_data_i[m*32 +: 32] = data;
        t.m     = m;
        t.cmd   = cmd;
        t.addr  = addr;
        t.data  = data;
        t.rdata = addr ^ 32'h0000_1234;
        sbq.push_back(t);
    endtask

    // Master drops its command at the edge that ends its done cycle
    task automatic releaseMaster(input int m);
        m_cmd_i[m*8 +: 8] = 8'h00;
        modelPtr = (m + 1) % N;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; m_cmd_i = '0; m_addr_i = '0; m_data_i = '0;
        dut_data_i = '0; dut_ready_i = 1'b1; dut_done_i = 1'b0;
        tick(); tick();
        rstn_i = 1'b1;
        tick();
        checks++; if (dut_cmd_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_cmd got=%h exp=00", dut_cmd_o); end
        checks++; if (dut_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got=%h exp=0", dut_addr_o); end
        checks++; if (dut_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got=%h exp=0", dut_data_o); end
        checks++; if (m_data_o !== '0) begin errors++; $display("[TB] FAIL rst_mdata got=%h exp=0", m_data_o); end
        checks++; if (m_done_o !== 2'b00) begin errors++; $display("[TB] FAIL rst_done got=%b exp=00", m_done_o); end
        checks++; if (m_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=00", m_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (grant_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_grant got=%0d exp=0", grant_o); end
`ifdef DBG_ARB_TIMEOUT_EN
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout got=%b exp=0", timeout_o); end
`endif
        modelPtr = 0;
    endtask

    // A done pulse with nothing in flight must not reach any master
    task automatic test_idle_done();
        dut_done_i = 1'b1; dut_data_i = 32'hCAFE_F00D;
        tick();
        dut_done_i = 1'b0;
        tick();
        checks++; if (m_done_o !== 2'b00) begin errors++; $display("[TB] FAIL idle_done got=%b exp=00", m_done_o); end
        checks++; if (m_data_o !== '0) begin errors++; $display("[TB] FAIL idle_data got=%h exp=0", m_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single();
        applyStimulus(0, 8'h01, 32'h100, 32'hA5);
        tick();
        exp = sbq.pop_front();
        checks++; if (dut_cmd_o !== exp.cmd) begin errors++; $display("[TB] FAIL single_cmd got=%h exp=%h", dut_cmd_o, exp.cmd); end
        checks++; if (dut_addr_o !== exp.addr) begin errors++; $display("[TB] FAIL single_addr got=%h exp=%h", dut_addr_o, exp.addr); end
        checks++; if (dut_data_o !== exp.data) begin errors++; $display("[TB] FAIL single_wdata got=%h exp=%h", dut_data_o, exp.data); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=1", busy_o); end
        checks++; if (m_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got=%b exp=01", m_ready_o); end
        tick(); tick();
        dut_done_i = 1'b1; dut_data_i = exp.rdata;
        tick();
        dut_done_i = 1'b0;
        checks++; if (m_done_o !== 2'b01) begin errors++; $display("[TB] FAIL single_done got=%b exp=01", m_done_o); end
        checks++; if (32'(m_data_o) !== exp.rdata) begin errors++; $display("[TB] FAIL single_rdata got=%h exp=%h", 32'(m_data_o), exp.rdata); end
        checks++; if (32'(m_data_o >> 32) !== 32'h0) begin errors++; $display("[TB] FAIL single_other got=%h exp=0", 32'(m_data_o >> 32)); end
        checks++; if (dut_cmd_o !== 8'h00) begin errors++; $display("[TB] FAIL single_relcmd got=%h exp=00", dut_cmd_o); end
        releaseMaster(0);
        tick();
        checks++; if (m_done_o !== 2'b00) begin errors++; $display("[TB] FAIL single_pulse got=%b exp=00", m_done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got=%b exp=0", busy_o); end
    endtask

    task automatic test_backpressure();
        dut_ready_i = 1'b0;
        applyStimulus(1, 8'h04, 32'h300, 32'h5A);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (dut_cmd_o !== 8'h00 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold got=%h/%b exp=00/0", dut_cmd_o, busy_o); end
        end
        dut_ready_i = 1'b1;
        tick();
        exp = sbq.pop_front();
        checks++; if (dut_cmd_o !== exp.cmd) begin errors++; $display("[TB] FAIL bp_cmd got=%h exp=%h", dut_cmd_o, exp.cmd); end
        checks++; if (grant_o !== 1'(exp.m)) begin errors++; $display("[TB] FAIL bp_grant got=%0d exp=%0d", grant_o, exp.m); end
        checks++; if (m_ready_o !== 2'b10) begin errors++; $display("[TB] FAIL bp_ready got=%b exp=10", m_ready_o); end
        dut_ready_i = 1'b0;
        #1;
        checks++; if (m_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL bp_readylow got=%b exp=00", m_ready_o); end
        dut_ready_i = 1'b1;
        dut_done_i = 1'b1; dut_data_i = exp.rdata;
        tick();
        dut_done_i = 1'b0;
        checks++; if (m_done_o !== 2'b10) begin errors++; $display("[TB] FAIL bp_done got=%b exp=10", m_done_o); end
        checks++; if (32'(m_data_o >> 32) !== exp.rdata) begin errors++; $display("[TB] FAIL bp_rdata got=%h exp=%h", 32'(m_data_o >> 32), exp.rdata); end
        checks++; if (32'(m_data_o) !== 32'h0) begin errors++; $display("[TB] FAIL bp_other got=%h exp=0", 32'(m_data_o)); end
        releaseMaster(1);
        tick();
    endtask

    // Two rounds of simultaneous requests served in round-robin order
    task automatic test_contention();
        int          waited;
        int          first;
        logic [1:0]  expOh;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) begin
                checks++; if (dut_cmd_o !== 8'h00) begin errors++; $display("[TB] FAIL cont_gap got=%h exp=00", dut_cmd_o); end
            end
            if (n == 0 || n == 2) begin
                first = modelPtr;
                applyStimulus(first, 8'h10 + 8'(n), 32'h1000 + 32'(n * 16) + 32'(first), 32'hB000 + 32'(first));
                applyStimulus(1 - first, 8'h20 + 8'(n), 32'h2000 + 32'(n * 16) + 32'(1 - first), 32'hC000 + 32'(1 - first));
            end
            waited = 0;
            while (dut_cmd_o === 8'h00 && waited < 20) begin
                tick();
                waited++;
            end
            checks++;
            if (waited >= 20) begin
                errors++; $display("[TB] FAIL cont_wait got=no grant exp=grant within 20 cycles");
                break;
            end
            if (waited != 1) begin errors++; $display("[TB] FAIL cont_latency got=%0d exp=1", waited); end
            exp = sbq.pop_front();
            expOh = 2'b01 << exp.m;
            checks++; if (grant_o !== 1'(exp.m)) begin errors++; $display("[TB] FAIL cont_grant got=%0d exp=%0d", grant_o, exp.m); end
            checks++; if (dut_cmd_o !== exp.cmd || dut_addr_o !== exp.addr) begin errors++; $display("[TB] FAIL cont_cmd got=%h/%h exp=%h/%h", dut_cmd_o, dut_addr_o, exp.cmd, exp.addr); end
            tick();
            dut_done_i = 1'b1; dut_data_i = exp.rdata;
            tick();
            dut_done_i = 1'b0;
            checks++; if (m_done_o !== expOh) begin errors++; $display("[TB] FAIL cont_done got=%b exp=%b", m_done_o, expOh); end
            checks++; if (32'(m_data_o >> (32 * exp.m)) !== exp.rdata) begin errors++; $display("[TB] FAIL cont_rdata got=%h exp=%h", 32'(m_data_o >> (32 * exp.m)), exp.rdata); end
            releaseMaster(exp.m);
            tick();
        end
    endtask

    // Master fields changing mid-transaction must not disturb the DUT side
    task automatic test_latching();
        applyStimulus(0, 8'h02, 32'h200, 32'h11);
        tick();
        exp = sbq.pop_front();
        checks++; if (dut_addr_o !== exp.addr) begin errors++; $display("[TB] FAIL latch_addr0 got=%h exp=%h", dut_addr_o, exp.addr); end
        m_addr_i[31:0] = 32'hFFFF;
        m_data_i[31:0] = 32'h9999;
        m_cmd_i[7:0]   = 8'h03;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (dut_addr_o !== exp.addr || dut_data_o !== exp.data || dut_cmd_o !== exp.cmd) begin
                errors++; $display("[TB] FAIL latch_hold got=%h/%h/%h exp=%h/%h/%h", dut_cmd_o, dut_addr_o, dut_data_o, exp.cmd, exp.addr, exp.data);
            end
        end
        dut_done_i = 1'b1; dut_data_i = exp.rdata;
        tick();
        dut_done_i = 1'b0;
        checks++; if (m_done_o !== 2'b01 || 32'(m_data_o) !== exp.rdata) begin errors++; $display("[TB] FAIL latch_done got=%b/%h exp=01/%h", m_done_o, 32'(m_data_o), exp.rdata); end
        releaseMaster(0);
        tick();
    endtask

    // Asynchronous reset in BUSY aborts silently; the held request is re-served
    task automatic test_reset_busy();
        applyStimulus(0, 8'h07, 32'h700, 32'h77);
        tick();
        checks++; if (busy_o !== 1'b1 || dut_cmd_o !== 8'h07) begin errors++; $display("[TB] FAIL rb_busy got=%b/%h exp=1/07", busy_o, dut_cmd_o); end
        #2 rstn_i = 1'b0;
        #1;
        checks++; if (dut_cmd_o !== 8'h00 || dut_addr_o !== 32'h0 || dut_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rb_dut got=%h/%h/%h exp=0/0/0", dut_cmd_o, dut_addr_o, dut_data_o); end
        checks++; if (busy_o !== 1'b0 || m_ready_o !== 2'b00 || m_done_o !== 2'b00) begin errors++; $display("[TB] FAIL rb_ctl got=%b/%b/%b exp=0/00/00", busy_o, m_ready_o, m_done_o); end
        dut_done_i = 1'b1; dut_data_i = 32'h5555;
        tick();
        checks++; if (m_done_o !== 2'b00 || m_data_o !== '0) begin errors++; $display("[TB] FAIL rb_nodone got=%b/%h exp=00/0", m_done_o, m_data_o); end
        dut_done_i = 1'b0;
        rstn_i = 1'b1;
        modelPtr = 0;
        tick();
        exp = sbq.pop_front();
        checks++; if (dut_cmd_o !== exp.cmd || grant_o !== 1'(exp.m)) begin errors++; $display("[TB] FAIL rb_regrant got=%h/%0d exp=%h/%0d", dut_cmd_o, grant_o, exp.cmd, exp.m); end
        tick();
        dut_done_i = 1'b1; dut_data_i = exp.rdata;
        tick();
        dut_done_i = 1'b0;
        checks++; if (m_done_o !== 2'b01 || 32'(m_data_o) !== exp.rdata) begin errors++; $display("[TB] FAIL rb_done got=%b/%h exp=01/%h", m_done_o, 32'(m_data_o), exp.rdata); end
        releaseMaster(0);
        tick();
    endtask

`ifdef DBG_ARB_TIMEOUT_EN
    // No DUT completion: the watchdog closes the transaction after 16 BUSY cycles
    task automatic test_timeout();
        int busyCycles;
        int waited;
        applyStimulus(1, 8'h0F, 32'hF00, 32'hF0);
        exp = sbq.pop_front();
        busyCycles = 0;
        waited = 0;
        while (m_done_o === 2'b00 && waited < 40) begin
            tick();
            waited++;
            if (m_done_o === 2'b00 && dut_cmd_o !== 8'h00) busyCycles++;
        end
        checks++; if (busyCycles != 16) begin errors++; $display("[TB] FAIL to_cycles got=%0d exp=16", busyCycles); end
        checks++; if (m_done_o !== 2'b10) begin errors++; $display("[TB] FAIL to_done got=%b exp=10", m_done_o); end
        checks++; if (32'(m_data_o >> 32) !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL to_data got=%h exp=deadbeef", 32'(m_data_o >> 32)); end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL to_flag got=%b exp=1", timeout_o); end
        releaseMaster(1);
        tick(); tick();
        checks++; if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL to_sticky got=%b/%b exp=1/0", timeout_o, busy_o); end
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_idle_done();
        test_single();
        test_backpressure();
        test_contention();
        test_latching();
        test_reset_busy();
`ifdef DBG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
